// File: rtl/async_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// async_load_sequencer_if
// Request handshake and async-load bank signals of async_load_sequencer.
//   master : request source / bank owner (drives req_valid, req_data, q_in)
//   slave  : the sequencer (drives req_ready, ld, ld_val, ff_en, busy, done, err)
// Signals:
//   req_valid/req_ready/req_data : load request handshake (WIDTH-bit value)
//   ld      : shared async-load strobe, drives arst of every bank cell
//   ld_val  : per-bit load value, drives rval of bank cell i from bit i
//   ff_en   : low while a load sequence is running (bank d-path must hold)
//   busy    : sequence in progress
//   done    : one-cycle pulse at sequence completion
//   q_in    : bank q readback
//   err     : sticky readback mismatch flag
// -----------------------------------------------------------------------------
interface async_load_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             ff_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q_in;
  logic             err;

  modport master (
    output req_valid, req_data, q_in,
    input  req_ready, ld, ld_val, ff_en, busy, done, err
  );

  modport slave (
    input  req_valid, req_data, q_in,
    output req_ready, ld, ld_val, ff_en, busy, done, err
  );
endinterface

// File: rtl/async_load_sequencer.sv
// -----------------------------------------------------------------------------
// async_load_sequencer
// Upstream control for a bank of async-load flip-flops. A request accepted on
// the valid/ready handshake is turned into a SETUP / PULSE / HOLD sequence on
// the shared strobe ld, with ld_val held stable across all strobe edges so no
// cell ever sees rval move while its arst is active.
//
// Ports:
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : async_load_sequencer_if.slave (handshake + bank signals)
//
// Parameters:
//   WIDTH     : bank width
//   SETUP_CYC : cycles ld_val is stable before ld rises   (>= 1)
//   PULSE_CYC : cycles ld stays high                      (>= 1)
//   HOLD_CYC  : cycles ld_val is stable after ld falls    (>= 1)
//
// Optional feature (macro ASYNC_LOAD_VERIFY_EN): on the last HOLD cycle the
// bank readback q_in is compared with ld_val; a mismatch sets the sticky err
// flag until reset. Without the macro err is tied 0 and q_in is ignored.
// -----------------------------------------------------------------------------
module async_load_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   arst_n,
  async_load_sequencer_if.slave  bus
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
    $error("async_load_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  localparam int MAX_CYC =
    (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  // Counter reload values: each phase lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e           r_state, w_state;
  logic [CNT_W-1:0] r_cnt,   w_cnt;
  logic             r_ld,    w_ld;
  logic [WIDTH-1:0] r_ld_val, w_ld_val;
  logic             r_done,  w_done;
  logic             r_busy,  w_busy;
  logic             r_ff_en, w_ff_en;
  logic             w_cnt_zero;

`ifdef ASYNC_LOAD_VERIFY_EN
  logic             r_err,   w_err;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_ld     = r_ld;
    w_ld_val = r_ld_val;
    w_done   = 1'b0;
`ifdef ASYNC_LOAD_VERIFY_EN
    w_err    = r_err;
`endif

    unique case (r_state)
      S_IDLE: begin
        // ld_val only ever changes here, on the accept edge.
        if (bus.req_valid) begin
          w_ld_val = bus.req_data;
          w_cnt    = SETUP_LOAD;
          w_state  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_ld    = 1'b1;
          w_cnt   = PULSE_LOAD;
          w_state = S_PULSE;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_ld    = 1'b0;
          w_cnt   = HOLD_LOAD;
          w_state = S_HOLD;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
`ifdef ASYNC_LOAD_VERIFY_EN
          // Bank has had the full hold window to settle; check readback.
          if (bus.q_in != r_ld_val) w_err = 1'b1;
`endif
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_ld    = 1'b0;
        w_state = S_IDLE;
      end
    endcase

    // busy/ff_en are registered alongside state so they line up with it.
    w_busy  = (w_state != S_IDLE);
    w_ff_en = !w_busy;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ld     <= 1'b0;
      r_ld_val <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ff_en  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_ld     <= w_ld;
      r_ld_val <= w_ld_val;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_ff_en  <= w_ff_en;
    end
  end

`ifdef ASYNC_LOAD_VERIFY_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_err <= 1'b0;
    else         r_err <= w_err;
  end
  assign bus.err = r_err;
`else
  logic w_unused_q_in;
  assign w_unused_q_in = ^bus.q_in;
  assign bus.err       = 1'b0;
`endif

  // Ready is the only combinational output; gated by arst_n so it is low
  // for the whole time reset is held.
  assign bus.req_ready = (r_state == S_IDLE) && arst_n;
  assign bus.ld        = r_ld;
  assign bus.ld_val    = r_ld_val;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.ff_en     = r_ff_en;

endmodule

// File: tb/tb_async_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_async_load_sequencer
// Two sequencer instances share clk/arst_n: A with 2/3/2 timing and B with
// 1/1/1 timing. Expected outputs come from a timeline model: for each DUT it
// remembers the cycle index of the last accept edge and the accepted value,
// and derives every output from the distance to that edge.
// -----------------------------------------------------------------------------
module tb_async_load_sequencer;

  localparam int W = 8;

  logic clk;
  logic arst_n;

  async_load_sequencer_if #(.WIDTH(W)) bus_a ();
  async_load_sequencer_if #(.WIDTH(W)) bus_b ();

  async_load_sequencer #(
    .WIDTH(W), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)
  ) dut_a (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_a)
  );

  async_load_sequencer #(
    .WIDTH(W), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
  ) dut_b (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Timeline model, index 0 = DUT A, 1 = DUT B.
  int           m_s  [2];
  int           m_p  [2];
  int           m_h  [2];
  int           m_e0 [2];
  logic [W-1:0] m_val[2];
  logic         m_err[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_e0[d]  = -1000;
      m_val[d] = '0;
      m_err[d] = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic [W-1:0] qa, input logic [W-1:0] qb);
    bus_a.req_valid = v;
    bus_a.req_data  = d;
    bus_a.q_in      = qa;
    bus_b.req_valid = v;
    bus_b.req_data  = d;
    bus_b.q_in      = qb;
  endtask

  // Advance the model by one clock edge using the inputs the bench drives.
  task automatic model_edge(input int d, input logic v, input logic [W-1:0] data,
                            input logic [W-1:0] q);
    int t;
    t = m_s[d] + m_p[d] + m_h[d];
`ifdef ASYNC_LOAD_VERIFY_EN
    if (cyc == m_e0[d] + t && q != m_val[d]) m_err[d] = 1'b1;
`endif
    // Idle again from the edge after the done cycle begins.
    if (v && cyc >= m_e0[d] + t + 1) begin
      m_e0[d]  = cyc;
      m_val[d] = data;
    end
  endtask

  task automatic cmp(input int d, input string nm, input logic ld, input logic [W-1:0] ldv,
                     input logic busy, input logic ffen, input logic done,
                     input logic rdy, input logic err);
    int   t, e;
    logic eb, eld, edn;
    t   = m_s[d] + m_p[d] + m_h[d];
    e   = m_e0[d];
    eb  = (cyc >= e) && (cyc < e + t);
    eld = (cyc >= e + m_s[d]) && (cyc < e + m_s[d] + m_p[d]);
    edn = (cyc == e + t);
    check($sformatf("%s ld @%0d", nm, cyc),     ld,   eld);
    check($sformatf("%s ld_val @%0d", nm, cyc), ldv,  m_val[d]);
    check($sformatf("%s busy @%0d", nm, cyc),   busy, eb);
    check($sformatf("%s ff_en @%0d", nm, cyc),  ffen, !eb);
    check($sformatf("%s done @%0d", nm, cyc),   done, edn);
    check($sformatf("%s ready @%0d", nm, cyc),  rdy,  !eb);
    check($sformatf("%s err @%0d", nm, cyc),    err,  m_err[d]);
  endtask

  // One clock: rising edge, model update, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0, bus_a.req_valid, bus_a.req_data, bus_a.q_in);
    model_edge(1, bus_b.req_valid, bus_b.req_data, bus_b.q_in);
    @(negedge clk);
    cmp(0, "A", bus_a.ld, bus_a.ld_val, bus_a.busy, bus_a.ff_en, bus_a.done,
        bus_a.req_ready, bus_a.err);
    cmp(1, "B", bus_b.ld, bus_b.ld_val, bus_b.busy, bus_b.ff_en, bus_b.done,
        bus_b.req_ready, bus_b.err);
  endtask

  task automatic check_in_reset(input string nm, input logic ld, input logic [W-1:0] ldv,
                                input logic busy, input logic ffen, input logic done,
                                input logic rdy, input logic err);
    check({nm, " rst ld"},     ld,   1'b0);
    check({nm, " rst ld_val"}, ldv,  '0);
    check({nm, " rst busy"},   busy, 1'b0);
    check({nm, " rst ff_en"},  ffen, 1'b1);
    check({nm, " rst done"},   done, 1'b0);
    check({nm, " rst ready"},  rdy,  1'b0);
    check({nm, " rst err"},    err,  1'b0);
  endtask

  // Hand-derived cycle table for DUT A (2/3/2): 0xA5 accepted at row 0,
  // 0x3C held valid through the sequence and accepted at row 8.
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         ld;
    logic         busy;
    logic         done;
    logic [W-1:0] ldv;
    logic         rdy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    m_s[0] = 2; m_p[0] = 3; m_h[0] = 2;
    m_s[1] = 1; m_p[1] = 1; m_h[1] = 1;
    model_reset();

    //           v     d      q      ld    busy  done  ldv    rdy
    tbl[0]  = '{1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[1]  = '{1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[3]  = '{1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[5]  = '{1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[7]  = '{1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[8]  = '{1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};

    // ---------------- power-on reset, checked mid-clock ----------------
    arst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    #12;
    check_in_reset("A", bus_a.ld, bus_a.ld_val, bus_a.busy, bus_a.ff_en, bus_a.done,
                   bus_a.req_ready, bus_a.err);
    check_in_reset("B", bus_b.ld, bus_b.ld_val, bus_b.busy, bus_b.ff_en, bus_b.done,
                   bus_b.req_ready, bus_b.err);
    @(negedge clk);
    arst_n = 1'b1;
    step();
    check("A ready after release", bus_a.req_ready, 1'b1);

    // ---------------- 1/1/1 corner on B ----------------
    drive(1'b1, 8'h5A, 8'h5A, 8'h5A);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 5) begin
        check($sformatf("B corner ld k=%0d", k),   bus_b.ld,   (k == 1));
        check($sformatf("B corner done k=%0d", k), bus_b.done, (k == 3));
      end
      drive(1'b0, 8'h00, 8'h5A, 8'h5A);
    end

    // ---------------- nominal + back-to-back table on A ----------------
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].q, tbl[i].q);
      step();
      check($sformatf("tbl[%0d] ld", i),     bus_a.ld,        tbl[i].ld);
      check($sformatf("tbl[%0d] busy", i),   bus_a.busy,      tbl[i].busy);
      check($sformatf("tbl[%0d] done", i),   bus_a.done,      tbl[i].done);
      check($sformatf("tbl[%0d] ld_val", i), bus_a.ld_val,    tbl[i].ldv);
      check($sformatf("tbl[%0d] ready", i),  bus_a.req_ready, tbl[i].rdy);
    end
    check("A err after matching readback", bus_a.err, 1'b0);

    // ---------------- reset one cycle after ld rises on A ----------------
    drive(1'b1, 8'hC3, 8'hC3, 8'hC3);
    step();
    drive(1'b0, 8'h00, 8'hC3, 8'hC3);
    step();
    step();
    check("A ld high before reset", bus_a.ld, 1'b1);
    step();
    #2;
    arst_n = 1'b0;
    #1;
    check_in_reset("A pulse", bus_a.ld, bus_a.ld_val, bus_a.busy, bus_a.ff_en, bus_a.done,
                   bus_a.req_ready, bus_a.err);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 10; k++) step();

    // ---------------- readback mismatch ----------------
    drive(1'b1, 8'hA5, 8'hA4, 8'hA4);
    step();
    drive(1'b0, 8'h00, 8'hA4, 8'hA4);
    for (int k = 0; k < 9; k++) step();
`ifdef ASYNC_LOAD_VERIFY_EN
    check("A err after mismatch", bus_a.err, 1'b1);
`else
    check("A err tied low", bus_a.err, 1'b0);
`endif
    drive(1'b1, 8'h11, 8'h11, 8'h11);
    step();
    drive(1'b0, 8'h00, 8'h11, 8'h11);
    for (int k = 0; k < 9; k++) step();
`ifdef ASYNC_LOAD_VERIFY_EN
    check("A err sticky", bus_a.err, 1'b1);
`else
    check("A err still low", bus_a.err, 1'b0);
`endif

    // ---------------- randomized traffic against the model ----------------
    for (int k = 0; k < 400; k++) begin
      logic         v;
      logic [W-1:0] d, qa, qb;
      v  = ($urandom_range(0, 2) != 0);
      d  = W'($urandom);
      qa = ($urandom_range(0, 7) == 0) ? W'($urandom) : m_val[0];
      qb = ($urandom_range(0, 7) == 0) ? W'($urandom) : m_val[1];
      drive(v, d, qa, qb);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_load_sequencer.md
Name: async_load_sequencer

Overview:
Upstream control stage for a bank of async-load flip-flops (cells with clk, arst, rval, d -> q).
- Accepts a load request carrying a WIDTH-bit value over a valid/ready handshake.
- Drives the bank's shared async-load strobe and per-bit load values with guaranteed setup, pulse and hold windows measured in clk cycles.
- Keeps rval stable around every edge of the strobe, so no cell sees a rval change while its arst is active.

Parameters:
WIDTH, 8, width of the load value / number of flip-flops in the bank
SETUP_CYC, 2, cycles ld_val is stable before ld rises (must be >= 1)
PULSE_CYC, 3, cycles ld stays high (must be >= 1)
HOLD_CYC, 2, cycles ld_val is stable after ld falls (must be >= 1)

Ports:
clk  input  1  clock, rising edge
arst_n  input  1  asynchronous active-low reset
req_valid  input  1  load request valid
req_ready  output  1  request accepted when valid and ready are both high on a clk edge
req_data  input  WIDTH  value to load into the bank
ld  output  WIDTH-independent 1  async-load strobe; drives arst of every bank cell
ld_val  output  WIDTH  load value; drives rval of bank cell i from bit i
ff_en  output  1  low while a load sequence is in progress; bank d-path owners hold d
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a sequence completes
q_in  input  WIDTH  bank q readback (used only with the optional feature)
err  output  1  sticky readback mismatch flag (tied 0 without the optional feature)

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: arst_n low immediately forces the following, independent of clk:
  - state=IDLE, counter=0
  - ld=0, ld_val=0, done=0, err=0
  - ff_en=1, busy=0
  - req_ready=0 while arst_n is low
- Reset deassertion: arst_n is released synchronously by the environment. Normal operation starts on the first rising edge after release.
- All outputs are registered except req_ready.
- req_ready = (state==IDLE) && arst_n. Combinational from state, no combinational path from req_valid.
- States:
  - IDLE: waits for a request. On accept, ld_val <= req_data, counter <= SETUP_CYC-1, go to SETUP.
  - SETUP: ld=0. At counter==0: ld <= 1, counter <= PULSE_CYC-1, go to PULSE. Otherwise decrement.
  - PULSE: ld=1. At counter==0: ld <= 0, counter <= HOLD_CYC-1, go to HOLD. Otherwise decrement.
  - HOLD: ld=0. At counter==0: done <= 1, go to IDLE. Otherwise decrement.
- Timing relative to accept edge E0:
  - ld rises at E0+SETUP_CYC.
  - ld falls at E0+SETUP_CYC+PULSE_CYC.
  - done is high for exactly the cycle following E0+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- ld_val changes only on an accept edge; it holds its value in IDLE between sequences.
- ff_en = !busy, registered alongside state.
- Back-to-back: a request may be accepted on the edge that ends the done cycle (done=1 while in IDLE). Minimum sequence spacing is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- req_valid and req_data changes outside IDLE are ignored; no queueing.
- Reset during PULSE: ld drops asynchronously with arst_n. The bank then holds its last async value; the request is lost and is not replayed.
- Counter width: $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). Instantiation with any of the three parameters < 1 fails at elaboration.

Optional Feature:
ASYNC_LOAD_VERIFY_EN
- Defined: on the final HOLD cycle (counter==0), q_in is compared with ld_val. A mismatch sets err <= 1. err stays set until arst_n is asserted.
- Not defined: no comparator; err is tied 0; q_in is unused.

Test Plan:
- Reset check: arst_n=0 mid-clock -> ld=0, ld_val=0, busy=0, ff_en=1, req_ready=0 immediately; after release and one clk edge, req_ready=1.
- Nominal (WIDTH=8, 2/3/2): req_data=0xA5 accepted at E0 -> ld_val=0xA5 after E0; ld=1 from E2 to E5; done=1 for the cycle after E7; busy=1 from E0 to E7.
- Back-to-back: second request 0x3C held valid during sequence -> ignored until IDLE; accepted on the edge ending the done cycle; ld_val does not change before that edge.
- Reset in PULSE: arst_n=0 one cycle after ld rises -> ld=0 asynchronously, state IDLE, no done pulse after release.
- Parameter corner: SETUP=PULSE=HOLD=1 -> ld high for exactly 1 cycle starting at E1; done in the cycle after E3.
- With ASYNC_LOAD_VERIFY_EN:
  - q_in=0xA5 at end of HOLD -> err stays 0.
  - q_in=0xA4 -> err=1 from the next cycle and persists across further sequences until reset.
